// File: rtl/pel_feeder_if.sv
`default_nettype none
// =============================================================================
// Module : pel_feeder_if
// Brief  : Memory-read and pixel-stream bundle between pel_feeder and its
//          TB/SW memories plus the head PE of the search array.
//          Optional macro: FEEDER_CYCCNT_EN (adds cyc_cnt).
// Rev    : 1.0
// =============================================================================
interface pel_feeder_if #(
  parameter int TB_SIZE = 16,
  parameter int SRCH    = 8
);
  localparam int c_sw_w  = TB_SIZE + 2*SRCH - 1;
  localparam int c_tb_aw = $clog2(TB_SIZE*TB_SIZE);
  localparam int c_sw_aw = $clog2(c_sw_w*c_sw_w);

  logic                 start;
  logic                 hold;
  logic [c_tb_aw-1:0]   tb_addr;
  logic                 tb_rd;
  logic [7:0]           tb_q;
  logic [c_sw_aw-1:0]   sw_addr;
  logic                 sw_rd;
  logic [7:0]           sw_q;
  logic                 en_tb;
  logic [7:0]           pel_tb;
  logic                 en_sw;
  logic [7:0]           pel_sw;
  logic                 busy;
  logic                 done;

`ifdef FEEDER_CYCCNT_EN
  logic [31:0]          cyc_cnt;

  modport master (
    input  start, hold, tb_q, sw_q,
    output tb_addr, tb_rd, sw_addr, sw_rd, en_tb, pel_tb, en_sw, pel_sw,
           busy, done, cyc_cnt
  );
  modport slave (
    output start, hold, tb_q, sw_q,
    input  tb_addr, tb_rd, sw_addr, sw_rd, en_tb, pel_tb, en_sw, pel_sw,
           busy, done, cyc_cnt
  );
`else
  modport master (
    input  start, hold, tb_q, sw_q,
    output tb_addr, tb_rd, sw_addr, sw_rd, en_tb, pel_tb, en_sw, pel_sw,
           busy, done
  );
  modport slave (
    output start, hold, tb_q, sw_q,
    input  tb_addr, tb_rd, sw_addr, sw_rd, en_tb, pel_tb, en_sw, pel_sw,
           busy, done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/pel_feeder.sv
`default_nettype none
// =============================================================================
// Module : pel_feeder
// Brief  : Reads the template block then every search-window offset strip and
//          streams both into the head PE. Optional macro: FEEDER_CYCCNT_EN.
// Rev    : 1.0
// =============================================================================
module pel_feeder #(
  parameter int TB_SIZE = 16,
  parameter int SRCH    = 8
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  pel_feeder_if.master bus
);
  localparam int c_sw_w   = TB_SIZE + 2*SRCH - 1;
  localparam int c_tb_aw  = $clog2(TB_SIZE*TB_SIZE);
  localparam int c_sw_aw  = $clog2(c_sw_w*c_sw_w);
  localparam int c_off_n  = 2*SRCH;
  localparam int c_off_w  = (c_off_n > 1) ? $clog2(c_off_n) : 1;
  localparam int c_seg_n  = TB_SIZE*c_sw_w;
  localparam int c_seg_w  = (c_seg_n > 1) ? $clog2(c_seg_n) : 1;

  localparam logic [c_tb_aw-1:0]  c_tb_last  = c_tb_aw'(TB_SIZE*TB_SIZE - 1);
  localparam logic [c_seg_w-1:0]  c_seg_last = c_seg_w'(c_seg_n - 1);
  localparam logic [c_off_w-1:0]  c_off_last = c_off_w'(c_off_n - 1);
  localparam logic [c_sw_aw-1:0]  c_sw_step  = c_sw_aw'(c_sw_w);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_TB   = 2'd1,
    S_STREAM_SW = 2'd2,
    S_FLUSH     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [c_tb_aw-1:0]   tb_cnt_q, tb_cnt_d;
  logic [c_off_w-1:0]   off_q, off_d;
  logic [c_seg_w-1:0]   seg_q, seg_d;
  logic [c_sw_aw-1:0]   base_q, base_d;
  logic [c_sw_aw-1:0]   sw_addr_q, sw_addr_d;
  logic                 en_tb_q, en_sw_q;
  logic [7:0]           pel_tb_q, pel_sw_q;
  logic                 tb_rd, sw_rd, done;

  // Within one offset the N rows are consecutive in the window, so the
  // address simply increments; only the offset change reloads from base.
  always_comb begin
    state_d   = state_q;
    tb_cnt_d  = tb_cnt_q;
    off_d     = off_q;
    seg_d     = seg_q;
    base_d    = base_q;
    sw_addr_d = sw_addr_q;
    tb_rd     = 1'b0;
    sw_rd     = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD_TB;
      end
      S_LOAD_TB: begin
        if (!bus.hold) begin
          tb_rd = 1'b1;
          if (tb_cnt_q == c_tb_last) begin
            tb_cnt_d = '0;
            state_d  = S_STREAM_SW;
          end else begin
            tb_cnt_d = tb_cnt_q + 1'b1;
          end
        end
      end
      S_STREAM_SW: begin
        if (!bus.hold) begin
          sw_rd = 1'b1;
          if (seg_q == c_seg_last) begin
            seg_d = '0;
            if (off_q == c_off_last) begin
              off_d     = '0;
              base_d    = '0;
              sw_addr_d = '0;
              state_d   = S_FLUSH;
            end else begin
              off_d     = off_q + 1'b1;
              base_d    = base_q + c_sw_step;
              sw_addr_d = base_q + c_sw_step;
            end
          end else begin
            seg_d     = seg_q + 1'b1;
            sw_addr_d = sw_addr_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (!bus.hold) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tb_cnt_q  <= '0;
      off_q     <= '0;
      seg_q     <= '0;
      base_q    <= '0;
      sw_addr_q <= '0;
      en_tb_q   <= 1'b0;
      en_sw_q   <= 1'b0;
      pel_tb_q  <= '0;
      pel_sw_q  <= '0;
    end else begin
      state_q   <= state_d;
      tb_cnt_q  <= tb_cnt_d;
      off_q     <= off_d;
      seg_q     <= seg_d;
      base_q    <= base_d;
      sw_addr_q <= sw_addr_d;
      en_tb_q   <= tb_rd;
      en_sw_q   <= sw_rd;
      if (en_tb_q) pel_tb_q <= bus.tb_q;
      if (en_sw_q) pel_sw_q <= bus.sw_q;
    end
  end

  assign bus.tb_addr = tb_cnt_q;
  assign bus.tb_rd   = tb_rd;
  assign bus.sw_addr = sw_addr_q;
  assign bus.sw_rd   = sw_rd;
  assign bus.en_tb   = en_tb_q;
  assign bus.pel_tb  = pel_tb_q;
  assign bus.en_sw   = en_sw_q;
  assign bus.pel_sw  = pel_sw_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done;

`ifdef FEEDER_CYCCNT_EN
  logic [31:0] cyc_cnt_q;

  // The accepting edge opens the first busy cycle, so counting starts at one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      cyc_cnt_q <= 32'd1;
    end else if (state_q != S_IDLE && !done && cyc_cnt_q != '1) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end

  assign bus.cyc_cnt = cyc_cnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pel_feeder.sv
`default_nettype none
// =============================================================================
// Module : tb_pel_feeder
// Brief  : Self-checking bench for pel_feeder (TB_SIZE=4, SRCH=2).
// Rev    : 1.0
// =============================================================================
module tb_pel_feeder;
  localparam int N     = 4;
  localparam int P     = 2;
  localparam int SW_W  = N + 2*P - 1;
  localparam int N_TB  = N*N;
  localparam int N_SW  = 2*P*N*SW_W;
  localparam int PASS  = 1 + N_TB + N_SW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pel_feeder_if #(.TB_SIZE(N), .SRCH(P)) bus ();
  pel_feeder #(.TB_SIZE(N), .SRCH(P)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  logic [7:0] tb_mem [N_TB];
  logic [7:0] sw_mem [SW_W*SW_W];
  int         sw_exp [$];

  // Synchronous one-cycle-latency memories.
  always @(posedge clk) begin
    if (bus.tb_rd) bus.tb_q <= tb_mem[bus.tb_addr];
    if (bus.sw_rd) bus.sw_q <= sw_mem[bus.sw_addr];
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] m_pel_tb = 8'd0;
  logic [7:0] m_pel_sw = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rn, input logic st, input logic hd);
    @(negedge clk);
    rst_n    = rn;
    bus.start = st;
    bus.hold  = hd;
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},    bus.busy,    0);
    chk({tag, "_done"},    bus.done,    0);
    chk({tag, "_tb_rd"},   bus.tb_rd,   0);
    chk({tag, "_sw_rd"},   bus.sw_rd,   0);
    chk({tag, "_tb_addr"}, bus.tb_addr, 0);
    chk({tag, "_sw_addr"}, bus.sw_addr, 0);
    chk({tag, "_en_tb"},   bus.en_tb,   0);
    chk({tag, "_en_sw"},   bus.en_sw,   0);
    chk({tag, "_pel_tb"},  bus.pel_tb,  0);
    chk({tag, "_pel_sw"},  bus.pel_sw,  0);
`ifdef FEEDER_CYCCNT_EN
    chk({tag, "_cyc_cnt"}, bus.cyc_cnt, 0);
`endif
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_zero("reset");
    m_pel_tb = 8'd0;
    m_pel_sw = 8'd0;
  endtask

  // mode 0: no hold; 1: random hold and stray starts; 2: 5-cycle hold at TB addr 9;
  // 3: start together with hold, hold kept two more cycles.
  task automatic run_pass(input int mode);
    logic [7:0] pix_tb [$];
    logic [7:0] pix_sw [$];
    int   tb_i = 0, sw_i = 0, holds = 0, busy_cyc = 0, hold_left = 0, post = 0;
    int   frozen = 0;
    logic m_busy = 1'b0, p_tb = 1'b0, p_sw = 1'b0, finished = 1'b0, held_once = 1'b0;
    logic st, hd, e_tb, e_sw, e_done;
    for (int cyc = 0; cyc < 600 && post < 3; cyc++) begin
      st = (cyc == 0);
      hd = 1'b0;
      if (!finished) begin
        case (mode)
          1: begin
            hd = ($urandom_range(0, 99) < 30);
            if (cyc > 0 && $urandom_range(0, 9) == 0) st = 1'b1;
          end
          2: begin
            if (tb_i == 9 && !held_once) begin hold_left = 5; held_once = 1'b1; end
            if (hold_left > 0) begin hd = 1'b1; hold_left--; end
          end
          3: hd = (cyc < 3);
          default: ;
        endcase
      end
      step(1'b1, st, hd);

      e_tb   = m_busy && !hd && tb_i < N_TB;
      e_sw   = m_busy && !hd && tb_i == N_TB && sw_i < N_SW;
      e_done = m_busy && !hd && tb_i == N_TB && sw_i == N_SW;

      chk("busy",   bus.busy,   m_busy);
      chk("tb_rd",  bus.tb_rd,  e_tb);
      chk("sw_rd",  bus.sw_rd,  e_sw);
      chk("done",   bus.done,   e_done);
      chk("en_tb",  bus.en_tb,  p_tb);
      chk("en_sw",  bus.en_sw,  p_sw);
      chk("pel_tb", bus.pel_tb, m_pel_tb);
      chk("pel_sw", bus.pel_sw, m_pel_sw);
      if (mode == 2 && hd && m_busy && tb_i == 9) chk("tb_addr_held", bus.tb_addr, 9);

      if (e_tb) begin
        chk("tb_addr", bus.tb_addr, tb_i);
        pix_tb.push_back(tb_mem[tb_i]);
        tb_i++;
      end
      if (e_sw) begin
        chk("sw_addr", bus.sw_addr, sw_exp[sw_i]);
        pix_sw.push_back(sw_mem[sw_exp[sw_i]]);
        sw_i++;
      end
      if (p_tb) m_pel_tb = pix_tb.pop_front();
      if (p_sw) m_pel_sw = pix_sw.pop_front();

      if (m_busy) begin
        busy_cyc++;
        if (hd) holds++;
      end
`ifdef FEEDER_CYCCNT_EN
      if (finished) chk("cyc_cnt_frozen", bus.cyc_cnt, frozen);
`endif
      if (e_done) begin
        chk("pass_len", cyc, PASS + holds);
        if (mode == 0) chk("pass_len_nohold", cyc, 129);
`ifdef FEEDER_CYCCNT_EN
        chk("cyc_cnt_done", bus.cyc_cnt, busy_cyc);
`endif
        frozen   = busy_cyc;
        finished = 1'b1;
      end
      if (finished) post++;

      p_tb = e_tb;
      p_sw = e_sw;
      if (e_done) m_busy = 1'b0;
      else if (!m_busy && st && !finished) m_busy = 1'b1;
    end
    chk("pass_finished", finished, 1);
  endtask

  task automatic reset_mid_pass();
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 27; i++) step(1'b1, 1'b0, 1'b0);
    chk("mid_sw_rd", bus.sw_rd, 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_zero("midrst1");
    step(1'b1, 1'b0, 1'b0);
    chk_zero("midrst2");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("abort_done", bus.done, 0);
      chk("abort_busy", bus.busy, 0);
    end
    m_pel_tb = 8'd0;
    m_pel_sw = 8'd0;
  endtask

  typedef struct packed {
    logic       rn, st, hd;
    logic       busy, rd;
    logic [3:0] addr;
    logic       en, dn;
  } vec_t;

  vec_t vt [14];

  initial begin
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    for (int i = 0; i < N_TB; i++) tb_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < SW_W*SW_W; i++) sw_mem[i] = 8'($urandom_range(0, 255));
    for (int v = 0; v < 2*P; v++)
      for (int r = v; r < v + N; r++)
        for (int c = 0; c < SW_W; c++) sw_exp.push_back(r*SW_W + c);

    //           rn    st    hd    busy  rd    addr  en    dn
    vt[0]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vt[1]  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    vt[2]  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0};
    vt[3]  = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0};
    vt[4]  = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0};
    vt[5]  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0};
    vt[6]  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0};
    vt[7]  = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0};
    vt[8]  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0};
    vt[9]  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vt[10] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vt[11] = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    vt[12] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    vt[13] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(vt[i].rn, vt[i].st, vt[i].hd);
      chk($sformatf("vec%0d_busy", i),    bus.busy,    vt[i].busy);
      chk($sformatf("vec%0d_tb_rd", i),   bus.tb_rd,   vt[i].rd);
      chk($sformatf("vec%0d_tb_addr", i), bus.tb_addr, vt[i].addr);
      chk($sformatf("vec%0d_en_tb", i),   bus.en_tb,   vt[i].en);
      chk($sformatf("vec%0d_done", i),    bus.done,    vt[i].dn);
      chk($sformatf("vec%0d_sw_rd", i),   bus.sw_rd,   0);
    end
    do_reset();

    run_pass(0);
    run_pass(2);
    run_pass(3);
    run_pass(1);
    run_pass(1);
    reset_mid_pass();
    run_pass(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
